// File: rtl/aud_session_ctrl.sv
// Audio recorder mode sequencer: codec init, record/play/pause/stop command
// pulses, recorded-length latch and elapsed-seconds timer.
module aud_session_ctrl #(
  parameter int unsigned              ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]        MAX_ADDR = 20'hFFFFF,
  parameter int unsigned              CLK_HZ   = 12000000,
  parameter int unsigned              TIME_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_0,
  input  logic              i_key_1,
  input  logic              i_key_2,
  input  logic              i_init_done,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_play_done,
  output logic              o_init_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_has_rec,
  output logic [2:0]        o_state,
  output logic [TIME_W-1:0] o_time
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_REC        = 3'd2,
    S_REC_PAUSE  = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t              state_q,      state_d;
  logic                init_sent_q,  init_sent_d;
  logic                init_start_q, init_start_d;
  logic                rec_start_q,  rec_start_d;
  logic                rec_pause_q,  rec_pause_d;
  logic                rec_stop_q,   rec_stop_d;
  logic                dsp_start_q,  dsp_start_d;
  logic                dsp_pause_q,  dsp_pause_d;
  logic                dsp_stop_q,   dsp_stop_d;
  logic [ADDR_W-1:0]   end_addr_q,   end_addr_d;
  logic                has_rec_q,    has_rec_d;
  logic [PRESC_W-1:0]  presc_q,      presc_d;
  logic [TIME_W-1:0]   time_q,       time_d;

  always_comb begin
    state_d      = state_q;
    init_sent_d  = init_sent_q;
    init_start_d = 1'b0;
    rec_start_d  = 1'b0;
    rec_pause_d  = 1'b0;
    rec_stop_d   = 1'b0;
    dsp_start_d  = 1'b0;
    dsp_pause_d  = 1'b0;
    dsp_stop_d   = 1'b0;
    end_addr_d   = end_addr_q;
    has_rec_d    = has_rec_q;
    presc_d      = presc_q;
    time_d       = time_q;

    // Timer advances on the current state; the start transitions below
    // override it with a clear, which only happens from IDLE anyway.
    if (state_q == S_REC || state_q == S_PLAY) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (time_q != '1) time_d = time_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    unique case (state_q)
      S_INIT: begin
        if (!init_sent_q) begin
          init_start_d = 1'b1;
          init_sent_d  = 1'b1;
        end else if (i_init_done) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_key_0) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
          has_rec_d   = 1'b0;
          time_d      = '0;
          presc_d     = '0;
        end else if (i_key_1 && has_rec_q) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
          time_d      = '0;
          presc_d     = '0;
        end
      end
      S_REC: begin
        if (i_key_2 || i_rec_addr == MAX_ADDR) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = i_rec_addr;
          has_rec_d  = 1'b1;
        end else if (i_key_0) begin
          state_d     = S_REC_PAUSE;
          rec_pause_d = 1'b1;
        end
      end
      S_REC_PAUSE: begin
        if (i_key_2) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = i_rec_addr;
          has_rec_d  = 1'b1;
        end else if (i_key_0) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_key_2 || i_play_done) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_key_1) begin
          state_d     = S_PLAY_PAUSE;
          dsp_pause_d = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (i_key_2) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (i_key_1) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_INIT;
      init_sent_q  <= 1'b0;
      init_start_q <= 1'b0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      dsp_start_q  <= 1'b0;
      dsp_pause_q  <= 1'b0;
      dsp_stop_q   <= 1'b0;
      end_addr_q   <= '0;
      has_rec_q    <= 1'b0;
      presc_q      <= '0;
      time_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_sent_q  <= init_sent_d;
      init_start_q <= init_start_d;
      rec_start_q  <= rec_start_d;
      rec_pause_q  <= rec_pause_d;
      rec_stop_q   <= rec_stop_d;
      dsp_start_q  <= dsp_start_d;
      dsp_pause_q  <= dsp_pause_d;
      dsp_stop_q   <= dsp_stop_d;
      end_addr_q   <= end_addr_d;
      has_rec_q    <= has_rec_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
    end
  end

  assign o_init_start = init_start_q;
  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_dsp_start  = dsp_start_q;
  assign o_dsp_pause  = dsp_pause_q;
  assign o_dsp_stop   = dsp_stop_q;
  assign o_end_addr   = end_addr_q;
  assign o_has_rec    = has_rec_q;
  assign o_state      = state_q;
  assign o_time       = time_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Directed bench for aud_session_ctrl with a 10-cycle second.
module tb_aud_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key0 = 1'b0, key1 = 1'b0, key2 = 1'b0;
  logic        init_done = 1'b0;
  logic [19:0] rec_addr = '0;
  logic        play_done = 1'b0;
  logic        init_start, rec_start, rec_pause, rec_stop;
  logic        dsp_start, dsp_pause, dsp_stop;
  logic [19:0] end_addr;
  logic        has_rec;
  logic [2:0]  state;
  logic [5:0]  tim;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aud_session_ctrl #(
    .ADDR_W(20), .MAX_ADDR(20'hFFFFF), .CLK_HZ(10), .TIME_W(6)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_key_0(key0), .i_key_1(key1), .i_key_2(key2),
    .i_init_done(init_done), .i_rec_addr(rec_addr), .i_play_done(play_done),
    .o_init_start(init_start), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
    .o_rec_stop(rec_stop), .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause),
    .o_dsp_stop(dsp_stop), .o_end_addr(end_addr), .o_has_rec(has_rec),
    .o_state(state), .o_time(tim)
  );

  // Pack all command pulses: {init, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
  function automatic logic [6:0] pulses();
    return {init_start, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop};
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k);
    key0 = (k == 0); key1 = (k == 1); key2 = (k == 2);
    tick();
    key0 = 1'b0; key1 = 1'b0; key2 = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    total++; if ({pulses(), state, tim, has_rec, end_addr} !== {7'b0, 3'd0, 6'd0, 1'b0, 20'd0}) begin
      bad++; $display("FAIL reset_vals got p=%b st=%0d t=%0d h=%b ea=%h", pulses(), state, tim, has_rec, end_addr);
    end
    rst_n = 1'b1;
    tick();
    total++; if (pulses() !== 7'b1000000 || state !== 3'd0) begin
      bad++; $display("FAIL init_start got p=%b st=%0d exp p=1000000 st=0", pulses(), state);
    end
    tick();
    total++; if (init_start !== 1'b0 || state !== 3'd0) begin
      bad++; $display("FAIL init_single got init=%b st=%0d exp 0/0", init_start, state);
    end
    press(0);
    total++; if (rec_start !== 1'b0 || state !== 3'd0) begin
      bad++; $display("FAIL init_keys got rs=%b st=%0d exp 0/0", rec_start, state);
    end
    init_done = 1'b1;
    tick();
    total++; if (state !== 3'd1) begin
      bad++; $display("FAIL init_to_idle got st=%0d exp 1", state);
    end
  endtask

  task automatic test_idle_ignore;
    press(1);
    total++; if (pulses() !== 7'b0 || state !== 3'd1) begin
      bad++; $display("FAIL play_no_rec got p=%b st=%0d exp 0/1", pulses(), state);
    end
    press(2);
    total++; if (pulses() !== 7'b0 || state !== 3'd1) begin
      bad++; $display("FAIL idle_key2 got p=%b st=%0d exp 0/1", pulses(), state);
    end
  endtask

  task automatic test_record;
    press(0);
    total++; if (pulses() !== 7'b0100000 || state !== 3'd2 || tim !== 6'd0) begin
      bad++; $display("FAIL rec_start got p=%b st=%0d t=%0d exp 0100000/2/0", pulses(), state, tim);
    end
    tick(25);
    total++; if (tim !== 6'd2 || pulses() !== 7'b0) begin
      bad++; $display("FAIL rec_time got t=%0d p=%b exp 2/0", tim, pulses());
    end
    press(0);
    total++; if (pulses() !== 7'b0010000 || state !== 3'd3) begin
      bad++; $display("FAIL rec_pause got p=%b st=%0d exp 0010000/3", pulses(), state);
    end
    tick(30);
    total++; if (tim !== 6'd2 || state !== 3'd3) begin
      bad++; $display("FAIL pause_hold got t=%0d st=%0d exp 2/3", tim, state);
    end
    press(0);
    total++; if (pulses() !== 7'b0100000 || state !== 3'd2) begin
      bad++; $display("FAIL rec_resume got p=%b st=%0d exp 0100000/2", pulses(), state);
    end
    press(1);
    total++; if (pulses() !== 7'b0 || state !== 3'd2) begin
      bad++; $display("FAIL rec_key1 got p=%b st=%0d exp 0/2", pulses(), state);
    end
    rec_addr = 20'h00123;
    press(2);
    total++; if (pulses() !== 7'b0001000 || state !== 3'd1 || end_addr !== 20'h00123 || has_rec !== 1'b1) begin
      bad++; $display("FAIL rec_stop got p=%b st=%0d ea=%h h=%b exp 0001000/1/00123/1", pulses(), state, end_addr, has_rec);
    end
    rec_addr = '0;
    tick(15);
    total++; if (tim !== 6'd2 || pulses() !== 7'b0 || end_addr !== 20'h00123) begin
      bad++; $display("FAIL idle_hold got t=%0d p=%b ea=%h exp 2/0/00123", tim, pulses(), end_addr);
    end
  endtask

  task automatic test_autostop;
    press(0);
    total++; if (rec_start !== 1'b1 || has_rec !== 1'b0 || tim !== 6'd0) begin
      bad++; $display("FAIL rerec_start got rs=%b h=%b t=%0d exp 1/0/0", rec_start, has_rec, tim);
    end
    rec_addr = 20'hFFFFF;
    tick();
    total++; if (pulses() !== 7'b0001000 || state !== 3'd1 || end_addr !== 20'hFFFFF || has_rec !== 1'b1) begin
      bad++; $display("FAIL auto_stop got p=%b st=%0d ea=%h h=%b exp 0001000/1/fffff/1", pulses(), state, end_addr, has_rec);
    end
    rec_addr = '0;
  endtask

  task automatic test_play;
    press(1);
    total++; if (pulses() !== 7'b0000100 || state !== 3'd4 || tim !== 6'd0) begin
      bad++; $display("FAIL play_start got p=%b st=%0d t=%0d exp 0000100/4/0", pulses(), state, tim);
    end
    press(0);
    total++; if (pulses() !== 7'b0 || state !== 3'd4) begin
      bad++; $display("FAIL play_key0 got p=%b st=%0d exp 0/4", pulses(), state);
    end
    press(1);
    total++; if (pulses() !== 7'b0000010 || state !== 3'd5) begin
      bad++; $display("FAIL play_pause got p=%b st=%0d exp 0000010/5", pulses(), state);
    end
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
    total++; if (pulses() !== 7'b0 || state !== 3'd5) begin
      bad++; $display("FAIL pause_done_ign got p=%b st=%0d exp 0/5", pulses(), state);
    end
    press(1);
    total++; if (pulses() !== 7'b0000100 || state !== 3'd4) begin
      bad++; $display("FAIL play_resume got p=%b st=%0d exp 0000100/4", pulses(), state);
    end
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
    total++; if (pulses() !== 7'b0000001 || state !== 3'd1) begin
      bad++; $display("FAIL play_done got p=%b st=%0d exp 0000001/1", pulses(), state);
    end
  endtask

  task automatic test_simultaneous;
    press(1);
    key1 = 1'b1; key2 = 1'b1; play_done = 1'b1;
    tick();
    key1 = 1'b0; key2 = 1'b0; play_done = 1'b0;
    total++; if (pulses() !== 7'b0000001 || state !== 3'd1) begin
      bad++; $display("FAIL play_prio got p=%b st=%0d exp 0000001/1", pulses(), state);
    end
    key0 = 1'b1; key1 = 1'b1;
    tick();
    key0 = 1'b0; key1 = 1'b0;
    total++; if (pulses() !== 7'b0100000 || state !== 3'd2) begin
      bad++; $display("FAIL idle_prio got p=%b st=%0d exp 0100000/2", pulses(), state);
    end
  endtask

  task automatic test_mid_reset;
    tick(35);
    total++; if (tim !== 6'd3 || state !== 3'd2) begin
      bad++; $display("FAIL rec_time3 got t=%0d st=%0d exp 3/2", tim, state);
    end
    rst_n = 1'b0;
    #1;
    total++; if ({pulses(), state, tim, has_rec, end_addr} !== {7'b0, 3'd0, 6'd0, 1'b0, 20'd0}) begin
      bad++; $display("FAIL async_reset got p=%b st=%0d t=%0d h=%b ea=%h", pulses(), state, tim, has_rec, end_addr);
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    total++; if (pulses() !== 7'b1000000 || state !== 3'd0 || has_rec !== 1'b0) begin
      bad++; $display("FAIL reinit got p=%b st=%0d h=%b exp 1000000/0/0", pulses(), state, has_rec);
    end
    tick();
    total++; if (state !== 3'd1 || init_start !== 1'b0) begin
      bad++; $display("FAIL reinit_idle got st=%0d init=%b exp 1/0", state, init_start);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_ignore();
    test_record();
    test_autostop();
    test_play();
    test_simultaneous();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
